// File: rtl/xfer_pkg.sv
// Shared definitions for the block-transfer front end.
//   OP_XFER / OP_XFER_SWAP : legal command opcodes
//   xfer_state_e           : controller state encoding
//   BEAT_W                 : width of the per-burst beat counter (BURST <= 15)
package xfer_pkg;

  localparam logic [2:0] OP_XFER      = 3'b000;
  localparam logic [2:0] OP_XFER_SWAP = 3'b001;

  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_FIN
  } xfer_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_XFER) || (op == OP_XFER_SWAP);
  endfunction

endpackage

// File: rtl/xfer_beat_cnt.sv
// Word/beat bookkeeping for xfer_burst_ctrl.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load remaining-word count from load_len, clear beat count
//   load_len    : transfer length (1..2**ADDR_W)
//   step        : one word written (remaining-1, beat+1)
//   clr_beat    : start a new burst (beat count to 0)
//   last_word   : the word being accepted now is the final one
//   burst_end   : the word being accepted now closes the current burst
module xfer_beat_cnt
  import xfer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BURST  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [ADDR_W:0] load_len,
  input  logic            step,
  input  logic            clr_beat,
  output logic            last_word,
  output logic            burst_end
);

  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  logic [ADDR_W:0]   r_rem;
  logic [BEAT_W-1:0] r_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_beat <= '0;
    end else if (load) begin
      r_rem  <= load_len;
      r_beat <= '0;
    end else if (step) begin
      r_rem  <= r_rem - REM_ONE;
      r_beat <= r_beat + BEAT_ONE;
    end else if (clr_beat) begin
      r_beat <= '0;
    end
  end

  // Both flags describe the beat currently offered, so the FSM can pick
  // its successor in the same cycle the beat is accepted.
  assign last_word = (r_rem == REM_ONE);
  assign burst_end = (r_beat == LAST_BEAT);

endmodule

// File: rtl/xfer_burst_ctrl.sv
// Block-transfer front end: takes one command at a time and streams data
// beats into the RAM write port in bursts of BURST beats separated by a
// one-cycle gap, optionally swapping the two halves of each word.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op              : OP_XFER or OP_XFER_SWAP, others rejected with err
//   cmd_addr, cmd_len   : first RAM address, word count (1..2**ADDR_W)
//   abort               : cancels the active transfer (BURST/GAP only)
//   in_valid/in_ready   : data beat handshake, in_data the beat
//   ram_we/addr/wdata   : registered RAM write port
//   busy                : transfer in progress
//   done / err          : single-cycle completion / error pulses
module xfer_burst_ctrl
  import xfer_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BURST  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned   HALF     = DATA_W / 2;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  xfer_state_e r_state;
  xfer_state_e w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic              r_swap;
  logic              r_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  logic w_cmd_acc;
  logic w_cmd_ok;
  logic w_beat_acc;
  logic w_beat_wr;
  logic w_load;
  logic w_clr_beat;
  logic w_err_set;
  logic w_last_word;
  logic w_burst_end;

  assign cmd_ready = (r_state == ST_IDLE);
  assign in_ready  = (r_state == ST_BURST);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FIN);
  assign ram_we    = r_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_wdata;
  assign err       = r_err;

  assign w_cmd_acc  = cmd_valid & cmd_ready;
  assign w_cmd_ok   = op_legal(cmd_op) && (cmd_len != '0);
  assign w_beat_acc = in_valid & in_ready;
  // A beat that meets abort in the same cycle is handshaken but discarded.
  assign w_beat_wr  = w_beat_acc & ~abort;

  xfer_beat_cnt #(
    .ADDR_W (ADDR_W),
    .BURST  (BURST)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .load_len  (cmd_len),
    .step      (w_beat_wr),
    .clr_beat  (w_clr_beat),
    .last_word (w_last_word),
    .burst_end (w_burst_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clr_beat  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          if (w_cmd_ok) begin
            w_load      = 1'b1;
            w_state_nxt = ST_BURST;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (abort) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_beat_acc) begin
          // Completion wins over a coinciding burst boundary.
          if (w_last_word) begin
            w_state_nxt = ST_FIN;
          end else if (w_burst_end) begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_clr_beat  = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_swap     <= 1'b0;
      r_we       <= 1'b0;
      r_ram_addr <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_we  <= w_beat_wr;
      r_err <= w_err_set;
      if (w_load) begin
        r_addr <= cmd_addr;
        r_swap <= (cmd_op == OP_XFER_SWAP);
      end else if (w_beat_wr) begin
        r_addr <= r_addr + ADDR_ONE;
      end
      if (w_beat_wr) begin
        r_ram_addr <= r_addr;
        r_wdata    <= r_swap ? {in_data[HALF-1:0], in_data[DATA_W-1:HALF]} : in_data;
      end
    end
  end

endmodule

// File: tb/tb_xfer_burst_ctrl.sv
module tb_xfer_burst_ctrl;
  import xfer_pkg::*;

  localparam int unsigned BURST = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic [7:0]  cmd_addr = 8'h00;
  logic [8:0]  cmd_len = 9'h000;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        busy;
  logic        done;
  logic        err;

  xfer_burst_ctrl #(
    .DATA_W (16),
    .ADDR_W (8),
    .BURST  (BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] dvec[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_err = 0;
  int unsigned n_done = 0;
  int unsigned exp_err = 0;
  int unsigned exp_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] swp(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  // Write monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        check("write_expected", 32'(sb.size() > 0), 32'(1));
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("ram_addr", 32'(ram_addr), 32'(e.addr));
          check("ram_wdata", 32'(ram_wdata), 32'(e.data));
          check("done_with_last", 32'(done), 32'(e.last));
        end
      end
      if (done) begin
        check("done_needs_we", 32'(ram_we), 32'(1));
        n_done++;
      end
      if (err) n_err++;
    end
  end

  task automatic fill_rand(input int unsigned n);
    dvec.delete();
    for (int unsigned i = 0; i < n; i++) dvec.push_back(16'($urandom));
  endtask

  task automatic end_test();
    @(negedge clk);
    #1;
    check("err_count", 32'(n_err), 32'(exp_err));
    check("done_count", 32'(n_done), 32'(exp_done));
    check("sb_empty", 32'(sb.size()), 32'(0));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_we"}, 32'(ram_we), 32'(0));
    check({tag, "_addr"}, 32'(ram_addr), 32'(0));
    check({tag, "_wdata"}, 32'(ram_wdata), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_err"}, 32'(err), 32'(0));
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
  endtask

  task automatic cmd_bad(input logic [2:0] op, input logic [8:0] len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = 8'h55;
    cmd_len   = len;
    #1 check("bad_cmd_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_err++;
    check("bad_err", 32'(err), 32'(1));
    check("bad_busy", 32'(busy), 32'(0));
    @(negedge clk);
    check("bad_err_clr", 32'(err), 32'(0));
    check("bad_busy2", 32'(busy), 32'(0));
  endtask

  // Drives one transfer from dvec. abort_at / rst_at >= 0 interrupt the
  // transfer once that many beats have been accepted.
  task automatic run_xfer(input logic [2:0] op, input logic [7:0] addr,
                          input int unsigned len, input int unsigned stall_pct,
                          input int abort_at, input int rst_at, input bit spam);
    logic [7:0]  a;
    int unsigned acc;
    int unsigned bcnt;
    int unsigned budget;
    bit          exp_gap;
    bit          gap_now;
    a = addr; acc = 0; bcnt = 0; budget = 0; exp_gap = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len[8:0];
    #1 check("cmd_ready_idle", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    cmd_valid = spam;
    cmd_op    = 3'b111;
    while (acc < len && budget < 4000) begin
      check("busy", 32'(busy), 32'(1));
      check("cmd_ready_busy", 32'(cmd_ready), 32'(0));
      check("in_ready", 32'(in_ready), 32'(!exp_gap));
      if (rst_at >= 0 && acc == 32'(rst_at)) begin
        in_valid = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 reset_checks("rst_mid");
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        repeat (2) @(negedge clk);
        reset_checks("rst_hold");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset_checks("rst_after");
        return;
      end
      if (abort_at >= 0 && acc == 32'(abort_at) && !exp_gap) begin
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = dvec[acc];
        @(negedge clk);
        abort     = 1'b0;
        in_valid  = 1'b0;
        cmd_valid = 1'b0;
        exp_err++;
        check("abort_err", 32'(err), 32'(1));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_cmd_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        check("abort_err_clr", 32'(err), 32'(0));
        return;
      end
      in_valid = ($urandom_range(99) >= stall_pct);
      in_data  = dvec[acc];
      gap_now  = exp_gap;
      exp_gap  = 0;
      if (in_valid && !gap_now) begin
        acc++;
        sb.push_back('{addr: a, data: (op == OP_XFER_SWAP) ? swp(in_data) : in_data,
                       last: (acc == len)});
        a++;
        bcnt++;
        if (bcnt == BURST && acc < len) begin
          exp_gap = 1;
          bcnt    = 0;
        end
      end
      budget++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    check("xfer_in_budget", 32'(budget < 4000), 32'(1));
    exp_done++;
    check("fin_done", 32'(done), 32'(1));
    check("fin_busy", 32'(busy), 32'(1));
    @(negedge clk);
    check("post_busy", 32'(busy), 32'(0));
    check("post_cmd_ready", 32'(cmd_ready), 32'(1));
    check("post_done", 32'(done), 32'(0));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 reset_checks("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: plain transfer, verbatim data
    dvec = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    run_xfer(OP_XFER, 8'h10, 3, 0, -1, -1, 1'b0);
    end_test();

    // 2: single swapped word
    dvec = '{16'h12AB};
    run_xfer(OP_XFER_SWAP, 8'h40, 1, 0, -1, -1, 1'b0);
    end_test();

    // 3: 12 words, continuous input, gaps after beats 5 and 10; cmd spam while busy
    fill_rand(12);
    run_xfer(OP_XFER, 8'h20, 12, 0, -1, -1, 1'b1);
    end_test();

    // 4: address wrap
    fill_rand(4);
    run_xfer(OP_XFER, 8'hFE, 4, 0, -1, -1, 1'b0);
    end_test();

    // 5: illegal op, zero length
    cmd_bad(3'b111, 9'd5);
    cmd_bad(OP_XFER, 9'd0);
    end_test();

    // 6: abort after beat 3, then reset after beat 3
    fill_rand(8);
    run_xfer(OP_XFER, 8'h80, 8, 0, 3, -1, 1'b0);
    end_test();
    fill_rand(8);
    run_xfer(OP_XFER_SWAP, 8'h90, 8, 0, -1, 3, 1'b0);
    end_test();

    // random stalls, swapped, crossing the wrap
    fill_rand(23);
    run_xfer(OP_XFER_SWAP, 8'hF0, 23, 30, -1, -1, 1'b0);
    end_test();

    // full RAM fill, address returns to start
    fill_rand(256);
    run_xfer(OP_XFER, 8'h37, 256, 10, -1, -1, 1'b0);
    end_test();
    check("full_fill_addr_wrap", 32'(dut.r_addr), 32'(8'h37));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
